// File: rtl/perf_mon_pkg.sv
// perf_mon_pkg: shared definitions for the pipeline run monitor.
//   state_e          - monitor run state, encoded as it appears on state_o
//   EV_*             - bit positions of the hazard channels inside event_i
//   trace_entry_w()  - width of one trace entry {pc, inst} for a given XLEN
package perf_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  localparam int EV_FLUSH_BRANCH = 0;
  localparam int EV_STALL_LD_USE = 1;
  localparam int EV_STALL_DIV    = 2;

  // One trace entry holds the PC in the upper half and the instruction in the lower half.
  function automatic int trace_entry_w(input int xlen);
    return 2 * xlen;
  endfunction

endpackage

// File: rtl/perf_trace_buf.sv
// perf_trace_buf: FIFO / ring buffer with a registered read port.
//   clk, rst      clock, asynchronous active-low reset
//   clr_i         synchronous clear (empties the buffer, clears overflow and read outputs)
//   push_i        write push_data_i this cycle
//   pop_i         read the oldest entry; data appears on rd_* the next cycle
//   rd_valid_o    rd_data_o holds a popped entry this cycle
//   count_o       number of entries held (0..DEPTH)
//   ovf_o         sticky: an entry was dropped (WRAP=0) or the oldest overwritten (WRAP=1)
module perf_trace_buf #(
  parameter int  DEPTH = 16,
  parameter int  WIDTH = 64,
  parameter bit  WRAP  = 1'b0,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             rd_valid_o,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  logic full_s, empty_s, pop_s, accept_s, lose_s, overwrite_s, write_s;

  assign full_s  = (count_q == CNT_W'(DEPTH));
  assign empty_s = (count_q == {CNT_W{1'b0}});
  assign pop_s   = pop_i & ~empty_s;
  // A pop in the same cycle frees a slot, so a push into a full buffer is then lossless.
  assign accept_s    = push_i & (~full_s | pop_s);
  assign lose_s      = push_i & full_s & ~pop_s;
  // In ring mode the lost push overwrites the oldest slot (wr_ptr == rd_ptr when full).
  assign overwrite_s = lose_s & WRAP;
  assign write_s     = accept_s | overwrite_s;

  // Next-state for pointers, occupancy, overflow flag and the registered read port.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q | lose_s;
    rd_valid_d = pop_s;
    rd_data_d  = rd_data_q;
    if (write_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s || overwrite_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (accept_s && !pop_s) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_s && !accept_s) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
    // Read uses the storage contents from before this cycle's write.
    if (pop_s) begin
      rd_data_d = mem_q[rd_ptr_q];
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Control and read-port registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= {WIDTH{1'b0}};
    end else if (clr_i) begin
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= {WIDTH{1'b0}};
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Entry storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (write_s && !clr_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign count_o    = count_q;
  assign ovf_o      = ovf_q;

endmodule

// File: rtl/pipeline_perf_monitor.sv
// pipeline_perf_monitor: run monitor for the pipelined processor.
//   start_i/clear_i/halt_i    run control (clear_i is a synchronous clear with top priority)
//   retire_i, wb_pc_i/inst_i  WB retire qualifier and traced PC/instruction
//   event_i                   one-hot-or-zero hazard flags (EV_* positions)
//   cycle_cnt_o, retired_cnt_o, event_cnt_o   saturating run counters
//   state_o                   IDLE / RUN / HALTED / TIMEOUT
//   trace_rd_*                pop interface of the WB trace buffer (1-cycle read latency)
//   trace_count_o, trace_ovf_o  trace occupancy and sticky overflow
module pipeline_perf_monitor
  import perf_mon_pkg::*;
#(
  parameter int  XLEN        = 32,
  parameter int  NUM_EVENTS  = 3,
  parameter int  CNT_W       = 32,
  parameter int  TRACE_DEPTH = 16,
  parameter bit  TRACE_WRAP  = 1'b0,
  parameter int  MAX_CYCLES  = 5000,
  localparam int TC_W        = $clog2(TRACE_DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic                        clear_i,
  input  logic                        halt_i,
  input  logic                        retire_i,
  input  logic [XLEN-1:0]             wb_pc_i,
  input  logic [XLEN-1:0]             wb_inst_i,
  input  logic [NUM_EVENTS-1:0]       event_i,
  output logic [CNT_W-1:0]            cycle_cnt_o,
  output logic [CNT_W-1:0]            retired_cnt_o,
  output logic [NUM_EVENTS*CNT_W-1:0] event_cnt_o,
  output logic [1:0]                  state_o,
  input  logic                        trace_rd_en_i,
  output logic                        trace_rd_valid_o,
  output logic [XLEN-1:0]             trace_rd_pc_o,
  output logic [XLEN-1:0]             trace_rd_inst_o,
  output logic [TC_W-1:0]             trace_count_o,
  output logic                        trace_ovf_o
);

  localparam int TRACE_W = trace_entry_w(XLEN);
  // A limit the counter can never reach (it saturates first) leaves the watchdog off.
  localparam bit WD_EN = (MAX_CYCLES != 0) && (longint'(MAX_CYCLES) <= (longint'(1) << CNT_W));
  localparam logic [CNT_W:0] WD_LIMIT = (CNT_W + 1)'(MAX_CYCLES);

  state_e           state_q;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             run_s, timeout_s;
  logic [TRACE_W-1:0] rd_entry_s;

  assign run_s     = (state_q == ST_RUN);
  // Compare in CNT_W+1 bits so cycle_cnt+1 cannot wrap to a false match.
  assign timeout_s = WD_EN && (({1'b0, cycle_q} + {{CNT_W{1'b0}}, 1'b1}) == WD_LIMIT);

  // Run-state FSM; halt takes precedence over the watchdog in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else if (clear_i) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (start_i) state_q <= ST_RUN;
        ST_RUN: begin
          if (halt_i) begin
            state_q <= ST_HALTED;
          end else if (timeout_s) begin
            state_q <= ST_TIMEOUT;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_HALTED:  state_q <= ST_HALTED;
        ST_TIMEOUT: state_q <= ST_TIMEOUT;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  // Saturating next values for the cycle and retire counters.
  always_comb begin
    cycle_d   = cycle_q;
    retired_d = retired_q;
    if (run_s && !(&cycle_q)) begin
      cycle_d = cycle_q + CNT_W'(1);
    end else begin
      cycle_d = cycle_q;
    end
    if (run_s && retire_i && !(&retired_q)) begin
      retired_d = retired_q + CNT_W'(1);
    end else begin
      retired_d = retired_q;
    end
  end

  // Cycle and retire counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q   <= {CNT_W{1'b0}};
      retired_q <= {CNT_W{1'b0}};
    end else if (clear_i) begin
      cycle_q   <= {CNT_W{1'b0}};
      retired_q <= {CNT_W{1'b0}};
    end else begin
      cycle_q   <= cycle_d;
      retired_q <= retired_d;
    end
  end

  for (genvar k = 0; k < NUM_EVENTS; k++) begin : g_ev
    logic [CNT_W-1:0] ev_q, ev_d;

    // Saturating next value for hazard channel k.
    always_comb begin
      if (run_s && event_i[k] && !(&ev_q)) begin
        ev_d = ev_q + CNT_W'(1);
      end else begin
        ev_d = ev_q;
      end
    end

    // Hazard channel k counter register.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        ev_q <= {CNT_W{1'b0}};
      end else if (clear_i) begin
        ev_q <= {CNT_W{1'b0}};
      end else begin
        ev_q <= ev_d;
      end
    end

    assign event_cnt_o[k*CNT_W +: CNT_W] = ev_q;
  end

  perf_trace_buf #(
    .DEPTH (TRACE_DEPTH),
    .WIDTH (TRACE_W),
    .WRAP  (TRACE_WRAP)
  ) u_trace (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (clear_i),
    .push_i      (run_s & retire_i),
    .push_data_i ({wb_pc_i, wb_inst_i}),
    .pop_i       (trace_rd_en_i),
    .rd_valid_o  (trace_rd_valid_o),
    .rd_data_o   (rd_entry_s),
    .count_o     (trace_count_o),
    .ovf_o       (trace_ovf_o)
  );

  assign trace_rd_pc_o   = rd_entry_s[TRACE_W-1:XLEN];
  assign trace_rd_inst_o = rd_entry_s[XLEN-1:0];
  assign cycle_cnt_o     = cycle_q;
  assign retired_cnt_o   = retired_q;
  assign state_o         = state_q;

endmodule
